// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: state encodings and default widths.
package instruction_loader_pkg;

    localparam int         ADDR_W_DEF    = 8;
    localparam int         DATA_W_DEF    = 8;
    localparam logic [7:0] NOP_INSTR_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

endpackage

// File: rtl/instruction_loader_sync_edge.sv
// Two-flop synchronizer for an asynchronous switch/button, plus a rising-edge pulse
// derived from one extra delay flop.
module instruction_loader_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1:0], async_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/instruction_loader.sv
// Program RAM owner for the 8-bit CPU: operator loads bytes via DIN/WR_STB in LOAD mode,
// the CPU fetches INSTR combinationally from PC in RUN mode and is held in reset otherwise.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_MODE,
    input  logic              WR_STB,
    input  logic [DATA_W-1:0] DIN,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] INSTR,
    output logic              CPU_HOLD,
    output logic [ADDR_W-1:0] WADDR,
    output logic [ADDR_W:0]   PROG_LEN,
    output logic              FULL,
    output logic              DONE,
    output logic [1:0]        STATE
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;

    logic lm;
    logic wr_rise;
    logic lm_rise_unused;
    logic wr_level_unused;
    logic wr_en;
    logic load_entry;
    logic load_exit;

    instruction_loader_sync_edge u_sync_lm (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .async_i (LOAD_MODE),
        .level_o (lm),
        .rise_o  (lm_rise_unused)
    );

    instruction_loader_sync_edge u_sync_wr (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .async_i (WR_STB),
        .level_o (wr_level_unused),
        .rise_o  (wr_rise)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = lm ? ST_LOAD : ST_RUN;
            ST_LOAD: if (!lm) state_d = ST_RUN;
            ST_RUN:  if (lm)  state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign load_exit  = (state_q == ST_LOAD) && (state_d == ST_RUN);
    assign wr_en      = (state_q == ST_LOAD) && wr_rise && !full_q;

    // A strobe landing on the same edge as the exit from LOAD still counts toward the length.
    always_comb begin
        waddr_d = waddr_q;
        full_d  = full_q;
        len_d   = len_q;
        done_d  = done_q;
        if (load_entry) begin
            waddr_d = '0;
            full_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            if (wr_en) begin
                waddr_d = waddr_q + ADDR_W'(1);
                if (waddr_q == '1) full_d = 1'b1;
            end
            if (load_exit) begin
                len_d = (full_q ? FULL_LEN : {1'b0, waddr_q}) + (ADDR_W + 1)'(wr_en);
            end
            if ((state_q == ST_RUN) && ({1'b0, PC} >= len_q)) done_d = 1'b1;
        end
        hold_d = !((state_q == ST_RUN) && (state_d == ST_RUN));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            waddr_q <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            waddr_q <= waddr_d;
            len_q   <= len_d;
            full_q  <= full_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    // Program RAM keeps its contents across reset; only the length bookkeeping is cleared.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[waddr_q] <= DIN;
        end
    end

    assign INSTR    = ((state_q == ST_RUN) && ({1'b0, PC} < len_q)) ? mem_q[PC] : NOP_INSTR;
    assign CPU_HOLD = hold_q;
    assign WADDR    = waddr_q;
    assign PROG_LEN = len_q;
    assign FULL     = full_q;
    assign DONE     = done_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  localparam int DEPTH = 256;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       LOAD_MODE = 1'b0;
  logic       WR_STB = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic [7:0] PC = 8'h00;
  logic [7:0] INSTR;
  logic       CPU_HOLD;
  logic [7:0] WADDR;
  logic [8:0] PROG_LEN;
  logic       FULL;
  logic       DONE;
  logic [1:0] STATE;

  always #5 CLK = ~CLK;

  instruction_loader #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .NOP_INSTR (8'h00)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOAD_MODE (LOAD_MODE),
    .WR_STB    (WR_STB),
    .DIN       (DIN),
    .PC        (PC),
    .INSTR     (INSTR),
    .CPU_HOLD  (CPU_HOLD),
    .WADDR     (WADDR),
    .PROG_LEN  (PROG_LEN),
    .FULL      (FULL),
    .DONE      (DONE),
    .STATE     (STATE)
  );

  typedef enum int {S_INSTR, S_HOLD, S_WADDR, S_LEN, S_FULL, S_DONE, S_STATE} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_mem [DEPTH];
  int         m_waddr = 0;
  int         m_len   = 0;
  bit         m_full  = 1'b0;
  bit         m_load  = 1'b0;

  function automatic logic [31:0] get_act(sel_e s);
    case (s)
      S_INSTR: return {24'b0, INSTR};
      S_HOLD:  return {31'b0, CPU_HOLD};
      S_WADDR: return {24'b0, WADDR};
      S_LEN:   return {23'b0, PROG_LEN};
      S_FULL:  return {31'b0, FULL};
      S_DONE:  return {31'b0, DONE};
      default: return {30'b0, STATE};
    endcase
  endfunction

  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = exp_q.pop_front();
      act = get_act(e.sel);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: actual %0h required %0h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(input sel_e s, input int v, input string n);
    exp_t e;
    e.sel  = s;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int exp_instr(input int pc);
    if (!m_load && pc < m_len) return int'(m_mem[pc]);
    return 0;
  endfunction

  task automatic press(input logic [7:0] b);
    DIN    = b;
    WR_STB = 1'b1;
    cyc(4);
    WR_STB = 1'b0;
    cyc(3);
    if (m_load && !m_full) begin
      m_mem[m_waddr] = b;
      m_waddr++;
      if (m_waddr == DEPTH) begin
        m_waddr = 0;
        m_full  = 1'b1;
      end
    end
  endtask

  task automatic enter_load();
    LOAD_MODE = 1'b1;
    cyc(4);
    m_load  = 1'b1;
    m_waddr = 0;
    m_full  = 1'b0;
    expect_val(S_STATE, 1, "load_state");
    expect_val(S_HOLD,  1, "load_hold");
    expect_val(S_WADDR, 0, "load_waddr");
    expect_val(S_FULL,  0, "load_full");
    expect_val(S_DONE,  0, "load_done");
    cyc(1);
  endtask

  task automatic enter_run();
    PC        = 8'h00;
    LOAD_MODE = 1'b0;
    cyc(5);
    m_load = 1'b0;
    m_len  = m_full ? DEPTH : m_waddr;
    expect_val(S_STATE, 2, "run_state");
    expect_val(S_LEN,   m_len, "run_len");
    expect_val(S_HOLD,  0, "run_hold");
    expect_val(S_DONE,  (m_len == 0) ? 1 : 0, "run_done");
    cyc(1);
  endtask

  task automatic check_instr(input int pc);
    PC = 8'(pc);
    expect_val(S_INSTR, exp_instr(pc), "instr");
    cyc(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    cyc(2);
    expect_val(S_STATE, 0, "rst_state");
    expect_val(S_HOLD,  1, "rst_hold");
    expect_val(S_WADDR, 0, "rst_waddr");
    expect_val(S_LEN,   0, "rst_len");
    expect_val(S_FULL,  0, "rst_full");
    expect_val(S_DONE,  0, "rst_done");
    cyc(1);
    RST = 1'b1;
    cyc(3);

    enter_load();
    press(8'h41);
    press(8'h82);
    press(8'hC3);
    enter_run();
    check_instr(0);
    check_instr(1);
    check_instr(2);
    PC = 8'd3;
    expect_val(S_INSTR, 0, "instr_past_end");
    expect_val(S_DONE,  0, "done_before_edge");
    cyc(1);
    expect_val(S_DONE, 1, "done_set");
    PC = 8'd4;
    cyc(1);
    expect_val(S_DONE, 1, "done_sticky");
    cyc(1);

    enter_load();
    for (int i = 0; i < DEPTH; i++) press(8'($urandom));
    expect_val(S_FULL,  1, "full_set");
    expect_val(S_WADDR, 0, "full_waddr_wrap");
    cyc(1);
    press(8'($urandom));
    expect_val(S_WADDR, 0, "full_ignore_waddr");
    expect_val(S_FULL,  1, "full_ignore_full");
    cyc(1);
    enter_run();
    check_instr(0);
    check_instr(255);
    check_instr(int'($urandom_range(1, 254)));

    enter_load();
    DIN    = 8'h5A;
    WR_STB = 1'b1;
    cyc(2);
    expect_val(S_WADDR, 0, "stb_before_write");
    cyc(1);
    expect_val(S_WADDR, 1, "stb_write_edge");
    cyc(50);
    expect_val(S_WADDR, 1, "stb_held_once");
    WR_STB = 1'b0;
    cyc(3);
    m_mem[0] = 8'h5A;
    m_waddr  = 1;
    expect_val(S_WADDR, 1, "stb_release");
    cyc(1);

    press(8'h77);
    DIN       = 8'hE9;
    WR_STB    = 1'b1;
    PC        = 8'h00;
    LOAD_MODE = 1'b0;
    cyc(5);
    m_mem[m_waddr] = 8'hE9;
    m_waddr++;
    m_load = 1'b0;
    m_len  = m_waddr;
    expect_val(S_STATE, 2, "coinc_state");
    expect_val(S_LEN,   m_len, "coinc_len");
    cyc(1);
    WR_STB = 1'b0;
    cyc(3);
    check_instr(m_len - 1);
    base = m_waddr;
    press(8'h11);
    press(8'h22);
    expect_val(S_WADDR, base, "run_stb_waddr");
    expect_val(S_LEN,   m_len, "run_stb_len");
    cyc(1);
    check_instr(0);
    check_instr(1);
    check_instr(2);

    for (int s = 0; s < 6; s++) begin
      int n;
      n = int'($urandom_range(0, 12));
      enter_load();
      for (int k = 0; k < n; k++) press(8'($urandom));
      enter_run();
      for (int k = 0; k < m_len; k++) check_instr(k);
      if ($urandom_range(0, 1) == 1) press(8'($urandom));
      for (int k = 0; k < 3; k++) check_instr(int'($urandom_range(0, 255)));
      PC = 8'(m_len);
      cyc(2);
      expect_val(S_DONE, 1, "rand_done");
      cyc(1);
    end

    enter_load();
    press(8'hA5);
    press(8'h5A);
    RST = 1'b0;
    expect_val(S_STATE, 0, "mid_rst_state");
    expect_val(S_HOLD,  1, "mid_rst_hold");
    expect_val(S_WADDR, 0, "mid_rst_waddr");
    expect_val(S_LEN,   0, "mid_rst_len");
    expect_val(S_FULL,  0, "mid_rst_full");
    expect_val(S_DONE,  0, "mid_rst_done");
    cyc(1);
    LOAD_MODE = 1'b0;
    PC        = 8'h00;
    RST       = 1'b1;
    m_load    = 1'b0;
    m_waddr   = 0;
    m_full    = 1'b0;
    m_len     = 0;
    cyc(5);
    expect_val(S_STATE, 2, "post_rst_state");
    expect_val(S_LEN,   0, "post_rst_len");
    expect_val(S_DONE,  1, "post_rst_done");
    expect_val(S_HOLD,  0, "post_rst_hold");
    cyc(1);
    check_instr(0);
    check_instr(1);

    cyc(3);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: only %0d checks performed", checks);
    end
    if (errors != 0) begin
      $display("FAIL summary: %0d checks, %0d errors", checks, errors);
    end else begin
      $display("PASS summary: %0d checks, 0 errors", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
